// File: rtl/detector_busy_monitor.sv
// Detector handshake monitor: times the detector busy line after each trigger,
// counts completed events and keeps sticky fault flags for the readout logic.
module detector_busy_monitor #(
  parameter int CLK_PER_US    = 24,
  parameter int T_US_ACK      = 100,
  parameter int T_US_BUSY_MAX = 20000,
  parameter int BUSY_W        = 16,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig_in,
  input  logic              trig_out,
  input  logic              err_clr,
  output logic              evt_valid,
  output logic [BUSY_W-1:0] busy_us,
  output logic [CNT_W-1:0]  evt_count,
  output logic [2:0]        err_flags,
  output logic [1:0]        state_dbg
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(CLK_PER_US - 1);
  localparam logic [BUSY_W-1:0] ACK_LAST   = BUSY_W'(T_US_ACK - 1);
  localparam logic [BUSY_W-1:0] BUSY_LAST  = BUSY_W'(T_US_BUSY_MAX - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    BUSY     = 2'd2,
    STUCK    = 2'd3
  } state_t;

  state_t            state, state_next;
  logic              s1, s2, s2_d;
  logic              trig_in_d, trig_start;
  logic [PW-1:0]     presc;
  logic [BUSY_W-1:0] us_cnt, us_next, us_inc;
  logic              us_tick, rise, fall;
  logic              evt_next;
  logic [2:0]        flag_set;

  assign rise      = s2 & ~s2_d;
  assign fall      = ~s2 & s2_d;
  assign us_tick   = (presc == PRESC_LAST);
  assign state_dbg = state;

  // Saturating increment; on the cycle of a tick this is the completed-us count.
  assign us_inc = (us_tick && us_cnt != '1) ? us_cnt + BUSY_W'(1) : us_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s2_d       <= 1'b0;
      trig_in_d  <= 1'b1;
      trig_start <= 1'b0;
    end else begin
      s1         <= trig_out;
      s2         <= s1;
      s2_d       <= s2;
      trig_in_d  <= trig_in;
      trig_start <= trig_in_d & ~trig_in;
    end
  end

  always_comb begin
    state_next = state;
    us_next    = us_cnt;
    evt_next   = 1'b0;
    flag_set   = 3'b000;
    case (state)
      IDLE: begin
        if (trig_start) begin
          if (!s2) begin
            state_next = WAIT_ACK;
            us_next    = '0;
          end else begin
            flag_set[0] = 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        flag_set[0] = trig_start;
        if (rise) begin
          state_next = BUSY;
          us_next    = '0;
        end else if (us_tick && us_cnt == ACK_LAST) begin
          flag_set[1] = 1'b1;
          state_next  = IDLE;
        end else begin
          us_next = us_inc;
        end
      end
      BUSY: begin
        flag_set[0] = trig_start;
        us_next     = us_inc;
        if (fall) begin
          state_next = IDLE;
          evt_next   = 1'b1;
        end else if (us_tick && us_cnt == BUSY_LAST) begin
          flag_set[2] = 1'b1;
          state_next  = STUCK;
        end
      end
      STUCK: begin
        flag_set[0] = trig_start;
        if (fall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The prescaler restarts on every state change so each state times from entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      presc     <= '0;
      us_cnt    <= '0;
      evt_valid <= 1'b0;
      busy_us   <= '0;
      evt_count <= '0;
      err_flags <= 3'b000;
    end else begin
      state     <= state_next;
      us_cnt    <= us_next;
      evt_valid <= evt_next;
      if (state_next != state) presc <= '0;
      else if (us_tick)        presc <= '0;
      else                     presc <= presc + PW'(1);
      if (evt_next) begin
        busy_us   <= us_inc;
        evt_count <= evt_count + CNT_W'(1);
      end
      err_flags <= (err_clr ? 3'b000 : err_flags) | flag_set;
    end
  end

endmodule

// File: tb/tb_detector_busy_monitor.sv
// Directed bench for detector_busy_monitor with shortened timing
// (4 clk/us, 2 us ack timeout, 10 us stuck timeout, 2-bit event counter).
module tb_detector_busy_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig_in;
  logic        trig_out;
  logic        err_clr;
  logic        evt_valid;
  logic [15:0] busy_us;
  logic [1:0]  evt_count;
  logic [2:0]  err_flags;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int evt_pulses = 0;
  int pulses_before;

  detector_busy_monitor #(
    .CLK_PER_US(4), .T_US_ACK(2), .T_US_BUSY_MAX(10), .BUSY_W(16), .CNT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trig_in(trig_in), .trig_out(trig_out),
    .err_clr(err_clr), .evt_valid(evt_valid), .busy_us(busy_us),
    .evt_count(evt_count), .err_flags(err_flags), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Independent tally of event pulses, sampled mid-cycle.
  always @(negedge clk) if (evt_valid) evt_pulses++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Trigger, ack 3 cycles later, busy held hi_cyc cycles; returns on the event edge.
  task automatic apply_event(input int hi_cyc);
    trig_in = 1'b0;
    tick(3);
    trig_out = 1'b1;
    tick(5);
    trig_in = 1'b1;
    tick(hi_cyc - 5);
    trig_out = 1'b0;
    tick(3);
  endtask

  initial begin
    rst_n = 1'b0; trig_in = 1'b1; trig_out = 1'b0; err_clr = 1'b0;
    tick(3);
    check_output("rst_evt_valid", 32'(evt_valid), 32'd0);
    check_output("rst_busy_us",   32'(busy_us),   32'd0);
    check_output("rst_evt_count", 32'(evt_count), 32'd0);
    check_output("rst_err_flags", 32'(err_flags), 32'd0);
    check_output("rst_state",     32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Normal event, 22 busy cycles -> 5 us
    trig_in = 1'b0;
    tick(2);
    check_output("norm_wait_ack", 32'(state_dbg), 32'd1);
    tick(1);
    trig_out = 1'b1;
    tick(3);
    check_output("norm_busy", 32'(state_dbg), 32'd2);
    tick(2);
    trig_in = 1'b1;
    tick(17);
    trig_out = 1'b0;
    tick(2);
    check_output("norm_pre_evt_state", 32'(state_dbg), 32'd2);
    check_output("norm_pre_evt_valid", 32'(evt_valid), 32'd0);
    tick(1);
    check_output("norm_evt_valid", 32'(evt_valid), 32'd1);
    check_output("norm_busy_us",   32'(busy_us),   32'd5);
    check_output("norm_evt_count", 32'(evt_count), 32'd1);
    check_output("norm_err_flags", 32'(err_flags), 32'd0);
    check_output("norm_idle",      32'(state_dbg), 32'd0);
    tick(1);
    check_output("norm_evt_pulse_end", 32'(evt_valid), 32'd0);
    tick(3);

    // No acknowledge: timeout 8 cycles after WAIT_ACK entry
    trig_in = 1'b0;
    tick(4);
    trig_in = 1'b1;
    tick(5);
    check_output("noack_still_wait", 32'(state_dbg), 32'd1);
    check_output("noack_no_flag",    32'(err_flags), 32'd0);
    tick(1);
    check_output("noack_idle",  32'(state_dbg), 32'd0);
    check_output("noack_flag",  32'(err_flags), 32'b010);
    check_output("noack_count", 32'(evt_count), 32'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_output("noack_clr", 32'(err_flags), 32'd0);
    tick(3);

    // Stuck: busy 60 cycles, stuck after 10 us in BUSY
    pulses_before = evt_pulses;
    trig_in = 1'b0;
    tick(3);
    trig_out = 1'b1;
    tick(5);
    trig_in = 1'b1;
    tick(37);
    check_output("stuck_pre_state", 32'(state_dbg), 32'd2);
    check_output("stuck_pre_flags", 32'(err_flags), 32'd0);
    tick(1);
    check_output("stuck_state", 32'(state_dbg), 32'd3);
    check_output("stuck_flag",  32'(err_flags), 32'b100);
    tick(17);
    trig_out = 1'b0;
    tick(2);
    check_output("stuck_hold", 32'(state_dbg), 32'd3);
    tick(1);
    check_output("stuck_release", 32'(state_dbg), 32'd0);
    tick(2);
    check_output("stuck_no_evt",     evt_pulses,        pulses_before);
    check_output("stuck_count",      32'(evt_count),    32'd1);
    check_output("stuck_busy_us_kept", 32'(busy_us),    32'd5);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(2);

    // Event after stuck: 30 busy cycles -> 7 us
    apply_event(30);
    check_output("post_stuck_evt",   32'(evt_valid), 32'd1);
    check_output("post_stuck_busy",  32'(busy_us),   32'd7);
    check_output("post_stuck_count", 32'(evt_count), 32'd2);
    check_output("post_stuck_flags", 32'(err_flags), 32'd0);
    tick(3);

    // Retrigger while BUSY
    pulses_before = evt_pulses;
    trig_in = 1'b0;
    tick(3);
    trig_out = 1'b1;
    tick(5);
    trig_in = 1'b1;
    tick(2);
    trig_in = 1'b0;
    tick(2);
    check_output("retrig_busy_flag",  32'(err_flags), 32'b001);
    check_output("retrig_busy_state", 32'(state_dbg), 32'd2);
    trig_in = 1'b1;
    tick(13);
    trig_out = 1'b0;
    tick(3);
    check_output("retrig_busy_us",   32'(busy_us),   32'd5);
    check_output("retrig_count",     32'(evt_count), 32'd3);
    tick(2);
    check_output("retrig_one_evt",   evt_pulses, pulses_before + 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_output("retrig_clr", 32'(err_flags), 32'd0);
    tick(2);

    // Trigger in IDLE while detector already busy; set beats simultaneous clear
    pulses_before = evt_pulses;
    trig_out = 1'b1;
    tick(4);
    trig_in = 1'b0;
    tick(1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_output("idle_retrig_state", 32'(state_dbg), 32'd0);
    check_output("idle_retrig_flag",  32'(err_flags), 32'b001);
    trig_in = 1'b1;
    tick(2);
    trig_out = 1'b0;
    tick(4);
    check_output("idle_retrig_count",  32'(evt_count), 32'd3);
    check_output("idle_retrig_no_evt", evt_pulses,     pulses_before);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_output("idle_retrig_clr", 32'(err_flags), 32'd0);
    tick(2);

    // Counter wrap on a 2-bit counter
    apply_event(22);
    check_output("wrap_count_0", 32'(evt_count), 32'd0);
    tick(3);
    apply_event(22);
    check_output("wrap_count_1", 32'(evt_count), 32'd1);
    tick(3);

    // Asynchronous reset mid-BUSY
    pulses_before = evt_pulses;
    trig_in = 1'b0;
    tick(3);
    trig_out = 1'b1;
    tick(5);
    trig_in = 1'b1;
    tick(4);
    check_output("mid_busy_state", 32'(state_dbg), 32'd2);
    rst_n = 1'b0;
    #1;
    check_output("arst_state",     32'(state_dbg), 32'd0);
    check_output("arst_busy_us",   32'(busy_us),   32'd0);
    check_output("arst_evt_count", 32'(evt_count), 32'd0);
    check_output("arst_evt_valid", 32'(evt_valid), 32'd0);
    check_output("arst_err_flags", 32'(err_flags), 32'd0);
    trig_out = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    check_output("arst_no_evt",    evt_pulses,     pulses_before);
    check_output("arst_idle",      32'(state_dbg), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
